// File: rtl/tc_ram_arb_pkg.sv
// tc_ram_arb_pkg: shared types and constants for the tc_ram_arbiter slice.
//   state_t        arbiter FSM states (CLEAR is used only when the clear
//                  feature TC_RAM_ARB_CLEAR_EN is compiled in)
//   REQ_A / REQ_B  requester identifiers (A = CPU, B = loader/DMA)
//   ADDR_W_DEF / DATA_W_DEF  default RAM geometry (256 x 8)
package tc_ram_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    CLEAR  = 2'd2
  } state_t;

endpackage

// File: rtl/tc_ram_arb_port.sv
// tc_ram_arb_port: per-requester front end of tc_ram_arbiter.
// Masks a request while its grant pulse is still high, registers the
// one-cycle grant pulse and captures read data from the RAM.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   req        requester's request line
//   win        arbiter picked this requester at the coming edge
//   capture    a read for this requester completes at the coming edge
//   ram_out    combinational RAM read data
//   eligible   req masked by the current grant pulse
//   gnt        one-cycle grant pulse
//   rvalid     one-cycle read-data-valid pulse
//   rdata      last read data, held between reads
module tc_ram_arb_port
  import tc_ram_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              win,
  input  logic              capture,
  input  logic [DATA_W-1:0] ram_out,
  output logic              eligible,
  output logic              gnt,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);

  // A requester still sees gnt high at the edge after its grant; without
  // this mask an unchanged req would be granted twice.
  assign eligible = req & ~gnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt    <= 1'b0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      gnt    <= win;
      rvalid <= capture;
      if (capture) rdata <= ram_out;
    end
  end

endmodule

// File: rtl/tc_ram_arbiter.sv
// tc_ram_arbiter: round-robin arbiter/sequencer giving requesters A (CPU)
// and B (loader/DMA) single-beat access to one single-port RAM that writes
// on the falling clock edge and reads combinationally.
// Optional feature macro: TC_RAM_ARB_CLEAR_EN (adds clr_req/clr_done and a
// one-cycle CLEAR state that pulses ram_rst).
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata      requester A command (held until a_gnt)
//   a_gnt/a_rvalid/a_rdata         requester A grant pulse, read return
//   b_*                            same for requester B
//   ram_rst/ram_load/ram_save      RAM clear, read enable, write enable
//   ram_address/ram_in/ram_out     RAM address, write data, read data
//   clr_req/clr_done               RAM clear request / completion pulse
//                                  (TC_RAM_ARB_CLEAR_EN only)
module tc_ram_arbiter
  import tc_ram_arb_pkg::*;
#(
  parameter int    UUID   = 0,
  parameter string NAME   = "",
  parameter int    ADDR_W = ADDR_W_DEF,
  parameter int    DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
`ifdef TC_RAM_ARB_CLEAR_EN
  input  logic              clr_req,
  output logic              clr_done,
`endif
  output logic              ram_rst,
  output logic              ram_load,
  output logic              ram_save,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);

  state_t            state, state_n;
  logic              rr_last, rr_last_n;   // requester that won the last contention
  logic              owner, owner_n;       // requester of the access in flight
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] in_n;
  logic              load_n, save_n;
  logic              a_elig, b_elig, a_win, b_win;
  logic              a_cap, b_cap;
  logic              clr_go;

  // A read issued at the previous edge completes at this one: ram_out has
  // been valid for the whole ACCESS cycle.
  assign a_cap = (state == ACCESS) && ram_load && (owner == REQ_A);
  assign b_cap = (state == ACCESS) && ram_load && (owner == REQ_B);

  tc_ram_arb_port #(.DATA_W(DATA_W)) u_port_a (
    .clk      (clk),
    .rst      (rst),
    .req      (a_req),
    .win      (a_win),
    .capture  (a_cap),
    .ram_out  (ram_out),
    .eligible (a_elig),
    .gnt      (a_gnt),
    .rvalid   (a_rvalid),
    .rdata    (a_rdata)
  );

  tc_ram_arb_port #(.DATA_W(DATA_W)) u_port_b (
    .clk      (clk),
    .rst      (rst),
    .req      (b_req),
    .win      (b_win),
    .capture  (b_cap),
    .ram_out  (ram_out),
    .eligible (b_elig),
    .gnt      (b_gnt),
    .rvalid   (b_rvalid),
    .rdata    (b_rdata)
  );

`ifdef TC_RAM_ARB_CLEAR_EN
  assign clr_go  = clr_req;
  assign ram_rst = rst | (state == CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) clr_done <= 1'b0;
    else     clr_done <= (state == CLEAR);
  end
`else
  assign clr_go  = 1'b0;
  assign ram_rst = rst;
`endif

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n   = IDLE;
    rr_last_n = rr_last;
    owner_n   = owner;
    addr_n    = ram_address;
    in_n      = ram_in;
    load_n    = 1'b0;
    save_n    = 1'b0;
    a_win     = 1'b0;
    b_win     = 1'b0;
    case (state)
      IDLE, ACCESS: begin
        if (clr_go) begin
          state_n = CLEAR;
        end else begin
          if (a_elig && b_elig) begin
            a_win     = (rr_last == REQ_B);
            b_win     = (rr_last == REQ_A);
            rr_last_n = a_win ? REQ_A : REQ_B;
          end else begin
            a_win = a_elig;
            b_win = b_elig;
          end
          if (a_win) begin
            state_n = ACCESS;
            owner_n = REQ_A;
            addr_n  = a_addr;
            in_n    = a_wdata;
            save_n  = a_we;
            load_n  = !a_we;
          end else if (b_win) begin
            state_n = ACCESS;
            owner_n = REQ_B;
            addr_n  = b_addr;
            in_n    = b_wdata;
            save_n  = b_we;
            load_n  = !b_we;
          end
        end
      end
      // CLEAR lasts exactly one cycle and never grants.
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_last     <= REQ_B;
      owner       <= REQ_A;
      ram_address <= '0;
      ram_in      <= '0;
      ram_load    <= 1'b0;
      ram_save    <= 1'b0;
    end else begin
      state       <= state_n;
      rr_last     <= rr_last_n;
      owner       <= owner_n;
      ram_address <= addr_n;
      ram_in      <= in_n;
      ram_load    <= load_n;
      ram_save    <= save_n;
    end
  end

endmodule

// File: tb/tb_tc_ram_arbiter.sv
// tb_tc_ram_arbiter: self-checking bench for tc_ram_arbiter with a
// behavioural RAM and a transaction-level reference model (memory array,
// pending-read record, round-robin preference).
module tb_tc_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a_req = 1'b0, a_we = 1'b0;
  logic [7:0] a_addr = '0, a_wdata = '0;
  logic       b_req = 1'b0, b_we = 1'b0;
  logic [7:0] b_addr = '0, b_wdata = '0;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       ram_rst, ram_load, ram_save;
  logic [7:0] ram_address, ram_in, ram_out;
`ifdef TC_RAM_ARB_CLEAR_EN
  logic       clr_req = 1'b0;
  logic       clr_done;
`endif

  always #5 clk = ~clk;

  tc_ram_arbiter #(.UUID(0), .NAME("tb"), .ADDR_W(8), .DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .a_req       (a_req),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .a_gnt       (a_gnt),
    .a_rvalid    (a_rvalid),
    .a_rdata     (a_rdata),
    .b_req       (b_req),
    .b_we        (b_we),
    .b_addr      (b_addr),
    .b_wdata     (b_wdata),
    .b_gnt       (b_gnt),
    .b_rvalid    (b_rvalid),
    .b_rdata     (b_rdata),
`ifdef TC_RAM_ARB_CLEAR_EN
    .clr_req     (clr_req),
    .clr_done    (clr_done),
`endif
    .ram_rst     (ram_rst),
    .ram_load    (ram_load),
    .ram_save    (ram_save),
    .ram_address (ram_address),
    .ram_in      (ram_in),
    .ram_out     (ram_out)
  );

  // Behavioural 256x8 RAM: write on falling edge, combinational read.
  logic [7:0] ram_mem [256];
  assign ram_out = ram_mem[ram_address];
  always @(negedge clk or posedge ram_rst) begin
    if (ram_rst) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 8'h00;
    end else if (ram_save) begin
      ram_mem[ram_address] <= ram_in;
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state.
  logic [7:0] m_mem [256];
  logic       m_gnt_a, m_gnt_b;
  int         m_rr;          // 0 = A won last contention, 1 = B
  logic       pend_v;
  int         pend_who;
  logic [7:0] pend_data;
  logic       e_a_gnt, e_b_gnt, e_a_rv, e_b_rv, e_load, e_save;
  logic [7:0] e_a_rd, e_b_rd, e_addr, e_in;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    m_gnt_a = 0; m_gnt_b = 0; m_rr = 1; pend_v = 0; pend_who = 0; pend_data = 0;
    e_a_gnt = 0; e_b_gnt = 0; e_a_rv = 0; e_b_rv = 0; e_load = 0; e_save = 0;
    e_a_rd = 0; e_b_rd = 0; e_addr = 0; e_in = 0;
  endtask

  task automatic model_access(input int who, input logic we, input logic [7:0] addr,
                              input logic [7:0] wdata);
    e_addr = addr;
    e_in   = wdata;
    if (we) begin
      m_mem[addr] = wdata;
      e_save = 1;
    end else begin
      e_load = 1;
      pend_v = 1; pend_who = who; pend_data = m_mem[addr];
    end
  endtask

  // Predict the outcome of the next rising edge from the current inputs.
  task automatic predict();
    logic ea, eb, wa, wb;
    ea = a_req && !m_gnt_a;
    eb = b_req && !m_gnt_b;
    wa = 0; wb = 0;
    if (ea && eb) begin
      if (m_rr == 1) wa = 1; else wb = 1;
      m_rr = wa ? 0 : 1;
    end else begin
      wa = ea; wb = eb;
    end
    e_a_rv = pend_v && (pend_who == 0);
    e_b_rv = pend_v && (pend_who == 1);
    if (e_a_rv) e_a_rd = pend_data;
    if (e_b_rv) e_b_rd = pend_data;
    pend_v = 0; e_load = 0; e_save = 0;
    if (wa) model_access(0, a_we, a_addr, a_wdata);
    if (wb) model_access(1, b_we, b_addr, b_wdata);
    e_a_gnt = wa; e_b_gnt = wb;
    m_gnt_a = wa; m_gnt_b = wb;
  endtask

  task automatic compare();
    check("a_gnt", a_gnt, e_a_gnt);
    check("b_gnt", b_gnt, e_b_gnt);
    check("a_rvalid", a_rvalid, e_a_rv);
    check("b_rvalid", b_rvalid, e_b_rv);
    check("a_rdata", a_rdata, e_a_rd);
    check("b_rdata", b_rdata, e_b_rd);
    check("ram_load", ram_load, e_load);
    check("ram_save", ram_save, e_save);
    check("ram_address", ram_address, e_addr);
    check("ram_in", ram_in, e_in);
    check("load_save_excl", ram_load & ram_save, 1'b0);
  endtask

  task automatic step();
    predict();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle_reqs();
    a_req = 0; b_req = 0;
  endtask

  task automatic drive_random();
    if (a_req) begin
      if (a_gnt) begin
        if ($urandom_range(1, 0) == 1) begin
          a_we = 1'($urandom_range(1, 0)); a_addr = 8'($urandom_range(7, 0)); a_wdata = 8'($urandom);
        end else a_req = 0;
      end else if ($urandom_range(3, 0) == 0) begin
        a_addr = 8'($urandom_range(7, 0)); a_wdata = 8'($urandom);
      end
    end else if ($urandom_range(9, 0) < 6) begin
      a_req = 1; a_we = 1'($urandom_range(1, 0));
      a_addr = 8'($urandom_range(7, 0)); a_wdata = 8'($urandom);
    end
    if (b_req) begin
      if (b_gnt) begin
        if ($urandom_range(1, 0) == 1) begin
          b_we = 1'($urandom_range(1, 0)); b_addr = 8'($urandom_range(7, 0)); b_wdata = 8'($urandom);
        end else b_req = 0;
      end else if ($urandom_range(3, 0) == 0) begin
        b_addr = 8'($urandom_range(7, 0)); b_wdata = 8'($urandom);
      end
    end else if ($urandom_range(9, 0) < 6) begin
      b_req = 1; b_we = 1'($urandom_range(1, 0));
      b_addr = 8'($urandom_range(7, 0)); b_wdata = 8'($urandom);
    end
  endtask

  initial begin
    int   b_cnt;
    logic b_prev;
    model_reset();

    // Reset state.
    #2 rst = 1'b1;
    #1;
    check("rst_a_gnt", a_gnt, 1'b0);
    check("rst_ram_load", ram_load, 1'b0);
    check("rst_ram_save", ram_save, 1'b0);
    check("rst_ram_address", ram_address, 8'h00);
    check("rst_a_rdata", a_rdata, 8'h00);
    check("rst_ram_rst", ram_rst, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("ram_rst_released", ram_rst, 1'b0);

    // A write 0x12 <- 0xAB, then A read 0x12.
    a_req = 1; a_we = 1; a_addr = 8'h12; a_wdata = 8'hAB;
    step();
    check("wr_gnt", a_gnt, 1'b1);
    a_we = 0;                       // new read request, req held high
    step();
    check("masked_no_gnt", a_gnt, 1'b0);
    step();
    check("rd_gnt", a_gnt, 1'b1);
    a_req = 0;
    step();
    check("rd_rvalid", a_rvalid, 1'b1);
    check("rd_data", a_rdata, 8'hAB);
    step();
    check("rvalid_one_cycle", a_rvalid, 1'b0);

    // Contention from reset: A wins first, then strict alternation.
    do_reset();
    a_req = 1; a_we = 0; a_addr = 8'h01;
    b_req = 1; b_we = 0; b_addr = 8'h02;
    step();
    check("cont_first_a", a_gnt, 1'b1);
    check("cont_addr0", ram_address, 8'h01);
    step();
    check("cont_then_b", b_gnt, 1'b1);
    check("cont_addr1", ram_address, 8'h02);
    step();
    check("cont_again_a", a_gnt, 1'b1);
    step();
    idle_reqs();
    step(); step();

    // B holds req for 10 cycles alone: grant every other cycle.
    b_req = 1; b_we = 0; b_addr = 8'h05;
    b_cnt = 0; b_prev = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("b_no_back2back", b_prev & b_gnt, 1'b0);
      b_prev = b_gnt;
      if (b_gnt) b_cnt++;
    end
    check("b_hold_count", b_cnt, 5);
    idle_reqs();
    step(); step();

    // Reset in the middle of a B read.
    b_req = 1; b_we = 0; b_addr = 8'h03;
    step();
    check("pre_rst_b_gnt", b_gnt, 1'b1);
    b_req = 0;
    #1 rst = 1'b1;
    #1;
    check("mid_rst_b_gnt", b_gnt, 1'b0);
    check("mid_rst_ram_load", ram_load, 1'b0);
    check("mid_rst_ram_address", ram_address, 8'h00);
    check("mid_rst_b_rdata", b_rdata, 8'h00);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_no_b_rvalid", b_rvalid, 1'b0);
    end
    a_req = 1; a_we = 0; a_addr = 8'h05;
    b_req = 1; b_we = 0; b_addr = 8'h06;
    step();
    check("post_rst_a_first", a_gnt, 1'b1);
    idle_reqs();
    step(); step(); step();

    // B write 0xFF @0x00, A read 0x00 in the next slot.
    b_req = 1; b_we = 1; b_addr = 8'h00; b_wdata = 8'hFF;
    step();
    check("bw_gnt", b_gnt, 1'b1);
    b_req = 0;
    a_req = 1; a_we = 0; a_addr = 8'h00;
    step();
    check("ar_gnt", a_gnt, 1'b1);
    a_req = 0;
    step();
    check("ar_rvalid", a_rvalid, 1'b1);
    check("ar_data", a_rdata, 8'hFF);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive_random();
      step();
    end
    idle_reqs();
    step(); step();

`ifdef TC_RAM_ARB_CLEAR_EN
    // Clear with a pending A read: CLEAR wins, then A is served.
    a_req = 1; a_we = 1; a_addr = 8'h10; a_wdata = 8'h55;
    step();
    check("clr_wr_gnt", a_gnt, 1'b1);
    a_we = 0; clr_req = 1;
    @(posedge clk); #1;
    clr_req = 0;
    check("clr_ram_rst", ram_rst, 1'b1);
    check("clr_no_gnt", a_gnt, 1'b0);
    @(posedge clk); #1;
    check("clr_done", clr_done, 1'b1);
    check("clr_ram_rst_end", ram_rst, 1'b0);
    check("clr_still_no_gnt", a_gnt, 1'b0);
    @(posedge clk); #1;
    check("clr_then_a_gnt", a_gnt, 1'b1);
    check("clr_done_pulse", clr_done, 1'b0);
    a_req = 0;
    @(posedge clk); #1;
    check("clr_rd_rvalid", a_rvalid, 1'b1);
    check("clr_rd_data", a_rdata, 8'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tc_ram_arbiter.md
Name: tc_ram_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for one 256x8 single-port RAM (load/save/address/in/out, write on clock falling edge, combinational read).
Requesters A (CPU) and B (loader/DMA) issue single-beat reads/writes through req/gnt handshakes; the arbiter owns every RAM control pin.
One access per two clocks per requester; back-to-back alternation under contention.

Parameters:
UUID, 0, instance identifier passed through for tooling
NAME, "", instance name passed through for tooling
ADDR_W, 8, RAM address width
DATA_W, 8, RAM data width

Ports:
clk  input  1  clock; all state on posedge
rst  input  1  asynchronous, active-high reset
a_req  input  1  requester A access request, held until a_gnt seen
a_we  input  1  A: 1=write, 0=read; stable while a_req
a_addr  input  ADDR_W  A address
a_wdata  input  DATA_W  A write data
a_gnt  output  1  A request accepted (one-cycle pulse)
a_rvalid  output  1  A read data valid (one-cycle pulse)
a_rdata  output  DATA_W  A read data, held until next A read completes
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B
ram_rst  output  1  RAM clear
ram_load  output  1  RAM read enable
ram_save  output  1  RAM write enable
ram_address  output  ADDR_W  RAM address
ram_in  output  DATA_W  RAM write data
ram_out  input  DATA_W  RAM read data

Behaviour:
- Reset (async, immediate): state=IDLE; rr_last=B (A wins first contention); all gnt/rvalid=0; rdata=0; ram_load/ram_save/ram_address/ram_in=0; ram_rst follows rst. An in-flight access is abandoned; its write may or may not have committed; no rvalid is produced.
- FSM states: IDLE, ACCESS (CLEAR only with the optional feature).
- At each posedge, eligible = req AND NOT (gnt currently high for that requester). This prevents a double grant while the requester drops or updates req.
- IDLE/ACCESS, no eligible requester -> IDLE. ram_load=ram_save=0; ram_address/ram_in hold their last values.
- One eligible requester -> it wins.
- Both eligible -> the one not equal to rr_last wins; rr_last=winner.
- On a win at posedge t:
  - Register winner id, ram_address=addr, ram_in=wdata, ram_save=we, ram_load=!we.
  - Pulse winner gnt during cycle t..t+1.
  - Enter ACCESS.
- ACCESS cycle: a write commits at the mid-cycle negedge. For a read, ram_out is captured into the winner's rdata at posedge t+1 and rvalid pulses during cycle t+1..t+2. Read latency is 2 posedges from req sampled; write latency to commit is 0.5 cycle after grant.
- A new grant may be issued at posedge t+1 (ACCESS->ACCESS) for the other requester, giving full-rate alternation.
- ram_load and ram_save are never both high. They are never high in IDLE.
- Requester changing addr/we/wdata while req high and gnt not yet seen: the value at the granting edge is used.

Optional Feature:
TC_RAM_ARB_CLEAR_EN
- With: adds input clr_req and output clr_done.
  - clr_req sampled in IDLE or at the end of ACCESS takes priority over both requesters.
  - Enter CLEAR for one cycle: ram_rst=1, no grants.
  - Return to IDLE and pulse clr_done for one cycle.
  - Pending reqs are served afterwards in round-robin order.
- Without: ports absent; ram_rst = rst; CLEAR state not generated.

Decomposition:
- Package tc_ram_arb_pkg holds:
  - state enum {IDLE, ACCESS, CLEAR}
  - requester id constants REQ_A=0, REQ_B=1
  - default ADDR_W/DATA_W
- One sub-module, tc_ram_arb_port, instantiated twice. It covers eligibility masking, the gnt pulse register, and rdata/rvalid capture. Arbitration, FSM and RAM drive stay in the top level.

Test Plan:
- A write 0x12 <- 0xAB, then A read 0x12 -> a_gnt one cycle each; a_rvalid 2 posedges after read req sampled; a_rdata=0xAB.
- A and B both req reads from reset (A 0x01, B 0x02) -> grants A, B, A... alternate every cycle; ram_address sequence 0x01, 0x02.
- B holds req for 10 cycles while A idle -> b_gnt every other cycle (eligibility mask); never two consecutive gnt pulses.
- Assert rst mid-ACCESS of a B read -> all outputs 0 immediately; no b_rvalid afterwards; the next grant after reset goes to A on contention.
- B write 0xFF to 0x00, A read 0x00 in the next grant slot -> a_rdata=0xFF; ram_load and ram_save never high together.
- (TC_RAM_ARB_CLEAR_EN) Write 0x55 @0x10, clr_req with A req pending -> ram_rst pulses 1 cycle, clr_done pulses, then A granted; read 0x10 returns 0x00.
